// File: rtl/dualrail_pkg.sv
// Shared types and constants for the dual-rail bit transmitter.
// State encoding, error codes and default sizing.
package dualrail_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BOTH    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT_ACK,
        RELEASE,
        WAIT_NULL,
        FINISH
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dualrail_bit_tx.sv
// Serial dual-rail transmitter: sends a word MSB first as one-hot in0/in1 pulses
// with a return-to-zero handshake against a detector's parity0/parity1 response.
module dualrail_bit_tx
    import dualrail_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             parity0,
    input  logic             parity1,
    output logic             in0,
    output logic             in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resp_vec,
    output logic             result,
    output logic [1:0]       err
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = 16;
    // Last count value before the phase is declared timed out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             p0s;
    logic             p1s;

    sync2 u_sync_p0 (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (parity0),
        .q    (p0s)
    );

    sync2 u_sync_p1 (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (parity1),
        .q    (p1s)
    );

    assign result = resp_vec[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_q   <= '0;
            idx      <= '0;
            cnt      <= '0;
            in0      <= 1'b0;
            in1      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            resp_vec <= '0;
            err      <= ERR_NONE;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        data_q   <= data;
                        resp_vec <= '0;
                        err      <= ERR_NONE;
                        idx      <= IDX_W'(WIDTH - 1);
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    in1   <= data_q[idx];
                    in0   <= ~data_q[idx];
                    cnt   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Rails are cleared on the way into FINISH so they are low during done.
                    if (p0s && p1s) begin
                        err   <= ERR_BOTH;
                        in0   <= 1'b0;
                        in1   <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (p0s ^ p1s) begin
                        resp_vec[idx] <= p1s;
                        state         <= RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        err   <= ERR_TIMEOUT;
                        in0   <= 1'b0;
                        in1   <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    in0   <= 1'b0;
                    in1   <= 1'b0;
                    cnt   <= '0;
                    state <= WAIT_NULL;
                end
                WAIT_NULL: begin
                    if (p0s && p1s) begin
                        err   <= ERR_BOTH;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (!p0s && !p1s) begin
                        if (idx == '0) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= DRIVE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err   <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    in0   <= 1'b0;
                    in1   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dualrail_bit_tx.sv
// Directed bench for dualrail_bit_tx: table of transfers against a behavioural
// responder, plus hand sequences for timeout timing, mid-transfer reset and held start.
module tb_dualrail_bit_tx;
    import dualrail_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;

    localparam logic [2:0] M_P0   = 3'd0;
    localparam logic [2:0] M_P1   = 3'd1;
    localparam logic [2:0] M_BOTH = 3'd2;
    localparam logic [2:0] M_NONE = 3'd3;
    localparam logic [2:0] M_ECHO = 3'd4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic         parity0 = 1'b0;
    logic         parity1 = 1'b0;
    logic         in0, in1, busy, done, result;
    logic [W-1:0] resp_vec;
    logic [1:0]   err;

    dualrail_bit_tx #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data    (data),
        .parity0 (parity0),
        .parity1 (parity1),
        .in0     (in0),
        .in1     (in1),
        .busy    (busy),
        .done    (done),
        .resp_vec(resp_vec),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      data;
        logic [7:0][2:0] ans;
        int              dly;
        logic [7:0]      exp_resp;
        logic [1:0]      exp_err;
        int              exp_nbits;
        logic [7:0]      exp_rails;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Responder / monitor state
    logic [7:0][2:0] ans;
    int              dly = 0;
    int              nbits = 0;
    int              done_cnt = 0;
    int              onehot_bad = 0;
    int              fin_bad = 0;
    int              rcnt = 0;
    int              cur = 0;
    logic            prev_any = 1'b0;
    logic [7:0]      rails_seen = '0;

    function automatic logic [7:0][2:0] all_mode(logic [2:0] m);
        logic [7:0][2:0] r;
        for (int i = 0; i < 8; i++) r[i] = m;
        return r;
    endfunction

    // Responder answers each rail rise after dly negedges, per-bit mode; drops when rails drop.
    always @(negedge clk) begin : mon
        logic any;
        any = in0 | in1;
        if (in0 && in1) onehot_bad++;
        if (done) begin
            done_cnt++;
            if (any) fin_bad++;
        end
        if (any) begin
            if (!prev_any) begin
                cur = 7 - nbits;
                nbits++;
                rails_seen = {rails_seen[6:0], in1};
                rcnt = 0;
            end
            if (rcnt >= dly && cur >= 0) begin
                case (ans[cur])
                    M_P0:    begin parity0 = 1'b1; parity1 = 1'b0; end
                    M_P1:    begin parity0 = 1'b0; parity1 = 1'b1; end
                    M_BOTH:  begin parity0 = 1'b1; parity1 = 1'b1; end
                    M_ECHO:  begin parity0 = in0;  parity1 = in1;  end
                    default: begin parity0 = 1'b0; parity1 = 1'b0; end
                endcase
            end
            rcnt++;
        end else begin
            parity0 = 1'b0;
            parity1 = 1'b0;
        end
        prev_any = any;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nbits      = 0;
        done_cnt   = 0;
        onehot_bad = 0;
        fin_bad    = 0;
        rails_seen = '0;
    endtask

    task automatic start_xfer(input logic [7:0] d);
        tick();
        data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        check({tag, ".done_seen"}, 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        ans = v.ans;
        dly = v.dly;
        clear_mon();
        start_xfer(v.data);
        wait_done(tag);
        check({tag, ".err"}, 32'(err), 32'(v.exp_err));
        tick();
        check({tag, ".busy_low"}, 32'(busy), 32'd0);
        repeat (3) tick();
        check({tag, ".resp_vec"}, 32'(resp_vec), 32'(v.exp_resp));
        check({tag, ".result"}, 32'(result), 32'(v.exp_resp[0]));
        check({tag, ".nbits"}, 32'(nbits), 32'(v.exp_nbits));
        check({tag, ".rails"}, 32'(rails_seen), 32'(v.exp_rails));
        check({tag, ".done_once"}, 32'(done_cnt), 32'd1);
        check({tag, ".onehot"}, 32'(onehot_bad), 32'd0);
        check({tag, ".fin_rails"}, 32'(fin_bad), 32'd0);
    endtask

    vec_t vt[9];

    initial begin
        int k;
        ans = all_mode(M_NONE);

        vt[0] = '{8'hA5, all_mode(M_P1),   2,  8'hFF, ERR_NONE,    8, 8'hA5};
        vt[1] = '{8'h03, all_mode(M_P0),   2,  8'h03, ERR_NONE,    8, 8'h03};
        vt[1].ans[1] = M_P1;
        vt[1].ans[0] = M_P1;
        vt[2] = '{8'h3C, all_mode(M_ECHO), 0,  8'h3C, ERR_NONE,    8, 8'h3C};
        vt[3] = '{8'h00, all_mode(M_ECHO), 0,  8'h00, ERR_NONE,    8, 8'h00};
        vt[4] = '{8'hFF, all_mode(M_ECHO), 13, 8'hFF, ERR_NONE,    8, 8'hFF};
        vt[5] = '{8'h5A, all_mode(M_P1),   2,  8'hC0, ERR_BOTH,    3, 8'h02};
        vt[5].ans[5] = M_BOTH;
        vt[6] = '{8'h81, all_mode(M_NONE), 0,  8'h00, ERR_TIMEOUT, 1, 8'h01};
        vt[7] = '{8'h81, all_mode(M_ECHO), 14, 8'h00, ERR_TIMEOUT, 1, 8'h01};
        vt[8] = '{8'hC3, all_mode(M_ECHO), 0,  8'hC2, ERR_TIMEOUT, 8, 8'hC3};
        vt[8].ans[0] = M_NONE;

        // Reset state
        repeat (3) tick();
        check("rst.in0", 32'(in0), 32'd0);
        check("rst.in1", 32'(in1), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.resp_vec", 32'(resp_vec), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Timeout lands exactly TO cycles after the rail rises
        ans = all_mode(M_NONE);
        dly = 0;
        clear_mon();
        start_xfer(8'h80);
        for (int i = 0; i < 20 && !(in0 | in1); i++) tick();
        check("to.rail_up", 32'(in1), 32'd1);
        k = 0;
        for (int i = 0; i < 40 && err != ERR_TIMEOUT; i++) begin
            tick();
            k++;
        end
        check("to.cycles", 32'(k), 32'(TO));
        check("to.done", 32'(done), 32'd1);
        check("to.rails_low", 32'(in0 | in1), 32'd0);
        tick();
        check("to.busy_low", 32'(busy), 32'd0);
        check("to.done_once", 32'(done_cnt), 32'd1);

        // Reset during bit 4 aborts without done
        ans = all_mode(M_P1);
        dly = 2;
        clear_mon();
        start_xfer(8'hA5);
        for (int i = 0; i < 200 && !(nbits == 4 && (in0 | in1)); i++) tick();
        check("abort.bit4_in0", 32'(in0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.in0", 32'(in0), 32'd0);
        check("abort.in1", 32'(in1), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("abort.no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        run_vec(vt[0], "after_rst");

        // start held high: data captured per transfer, restart only after done
        ans = all_mode(M_ECHO);
        dly = 0;
        clear_mon();
        tick();
        data  = 8'hA5;
        start = 1'b1;
        tick();
        check("held.busy1", 32'(busy), 32'd1);
        data = 8'h3C;
        wait_done("held1");
        check("held1.rails", 32'(rails_seen), 32'hA5);
        check("held1.resp", 32'(resp_vec), 32'hA5);
        tick();
        check("held.idle_busy", 32'(busy), 32'd0);
        check("held.idle_done", 32'(done), 32'd0);
        clear_mon();
        tick();
        check("held.restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("held2");
        repeat (2) tick();
        check("held2.rails", 32'(rails_seen), 32'h3C);
        check("held2.resp", 32'(resp_vec), 32'h3C);
        check("held2.err", 32'(err), 32'(ERR_NONE));
        check("held2.done_once", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
